mmu_utlb: RTL and testbench
===========================

# mmu_utlb

Parametrised address-translation front end with a fully associative micro-TLB (µTLB), shared by the instruction and data pipelines through the `IS_DATA` parameter. It sits between the fetch or memory-access stage and the cache tag compare. It maps kseg0/kseg1 directly and serves mapped segments from the µTLB, refilling from the main TLB over a request/grant handshake on a miss. It produces the physical tag, the uncached attribute, and the full exception code (AdEL/AdES/TLBL/TLBS/Mod, refill flag).

## Interface
- `ENTRIES`, 4, µTLB entries; power of two, 2..16
- `IS_DATA`, 0, 0 = fetch port (loads only, word alignment); 1 = data port (loads/stores, size-based alignment)
- `ASID_W`, 8, ASID width
- `TAG_W`, 20, physical tag width (PA[31:12])
- `clk` in 1, clock
- `rst` in 1, synchronous, active-high reset
- `req_valid` in 1, translation request
- `req_ready` out 1, request accepted when `req_valid && req_ready`
- `req_vaddr` in 32, virtual address
- `req_store` in 1, store access; ignored when `IS_DATA=0`
- `req_size` in 2, 0 = byte, 1 = half, 2 = word; ignored when `IS_DATA=0` (word assumed)
- `asid` in ASID_W, current EntryHi.ASID
- `cfg_k0` in 3, Config.K0
- `flush` in 1, invalidate all µTLB entries (TLBWI/TLBWR/TLBR/ASID write)
- `resp_valid` out 1, one-cycle response pulse
- `resp_tag` out TAG_W, physical tag; 0 when `resp_exc=1`
- `resp_uncache` out 1, uncached access
- `resp_exc` out 1, exception
- `resp_exccode` out 5, ExcCode
- `resp_refill` out 1, TLB refill (vector offset 0x000)
- `tlb_req` out 1, main-TLB lookup request
- `tlb_vpn2` out 19, VA[31:13] of the pending miss
- `tlb_odd` out 1, VA[12]
- `tlb_asid` out ASID_W, captured ASID
- `tlb_gnt` in 1, main TLB answers this cycle; all `tlb_*` inputs below are valid only when `tlb_gnt=1`
- `tlb_hit` `tlb_v` `tlb_d` `tlb_g` in 1 each, lookup result
- `tlb_pfn` in TAG_W, page frame
- `tlb_c` in 3, cache attribute

## Operation
- FSM states: IDLE, WAIT, FILL. `req_ready = (state==IDLE)`.
- On acceptance, capture vaddr/store/size/asid and classify the segment:
  - kseg0 is VA[31:29]=100; kseg1 is 101; every other VA is mapped.
- Alignment is checked first and takes priority over all TLB exceptions:
  - half requires VA[0]=0; word requires VA[1:0]=00.
  - Violation → AdEL (0x04), or AdES (0x05) for a store. Response on the next cycle with no TLB access.
- Unmapped segments:
  - Tag = {3'b0, VA[28:12]}.
  - Uncache: kseg0 uses `cfg_k0!=3'd3` sampled at acceptance; kseg1 is always uncached.
  - Response on the next cycle.
- Mapped segments, µTLB hit:
  - Match condition: `valid && vpn==VA[31:12]`, plus the ASID/G check when enabled.
  - Response on the next cycle with the entry's pfn and `c!=3`.
  - Store to an entry with d=0 → Mod (0x01), refill=0.
- Mapped segments, µTLB miss: go to WAIT.
  - Hold `tlb_req=1` with the captured vpn2/odd/asid until `tlb_gnt`, then go to FILL.
  - Latch the result in FILL and respond.
- FILL results:
  - hit=0 → TLBL (0x02) or TLBS (0x03), refill=1.
  - hit=1, v=0 → TLBL/TLBS, refill=0.
  - hit=1, v=1, store, d=0 → Mod.
  - Only hit && v results are written into the µTLB. The write happens in FILL, into the entry at the round-robin pointer. The pointer increments modulo ENTRIES after each write.
- Return to IDLE after the response.
- `flush`:
  - Clears all valid bits the next cycle.
  - A flush in WAIT or FILL suppresses that fill's write; the response is still delivered.
  - If flush and a fill write occur in the same cycle, flush wins.
- If multiple entries match (which must not happen), the lowest index wins.

## Timing
- Reset values: state=IDLE, `req_ready=1` after reset, `resp_valid=0`, `resp_tag=0`, `resp_uncache=0`, `resp_exc=0`, `resp_exccode=0`, `resp_refill=0`, `tlb_req=0`, all valid bits=0, pointer=0.
- Latency from acceptance to response:
  - Hit, unmapped, or address error: 1 cycle.
  - Miss: 2 + N cycles, where N is the number of cycles `tlb_gnt` stays low after `tlb_req` rises.
- `tlb_req` rises the cycle after acceptance. It drops the cycle after `tlb_gnt` and never re-asserts for the same request.
- `rst` asserted in any state → IDLE next cycle: the pending response is dropped and `tlb_req` is deasserted.
- A request accepted in the cycle a response pulses is legal: back-to-back hits give one response per cycle.

## Configuration
- `UTLB_ASID_TAG_EN` defined:
  - Entries store ASID and G.
  - Match additionally requires `g || entry_asid==asid`.
  - An ASID change alone does not require `flush`.
- Undefined:
  - No ASID/G storage.
  - The match ignores ASID; the control logic must pulse `flush` on every EntryHi.ASID write.

## Test plan
- Reset, then word fetch at 0xBFC00000 → `resp_valid` at +1, tag 0x1FC00, uncache=1, exc=0.
- `cfg_k0=3`, access at 0x80001234 → tag 0x00001, uncache=0. With `cfg_k0=2` → uncache=1.
- Data load at 0x00400000, µTLB empty, `tlb_gnt` after 3 cycles with hit=1, v=1, pfn=0x12345, c=3 → response at +5, tag 0x12345. Repeat → response at +1 with `tlb_req` staying 0.
- Miss with hit=0 → exccode 0x02, refill=1. Store miss with hit=1, v=0 → 0x03, refill=0. Store on a cached entry with d=0 → 0x01.
- IS_DATA=1 half store at 0x00400001 → AdES (0x05) at +1, `tlb_req` never asserted.
- Fill ENTRIES+1 distinct pages → the first page misses again (round robin). `flush` during WAIT → response delivered, next access to the same page misses.

Source files
------------

// File: rtl/mmu_utlb.sv
// Address translation front end: kseg0/kseg1 direct map, fully associative micro-TLB with main-TLB refill.
// Optional ASID/G tagging of micro-TLB entries is enabled by defining UTLB_ASID_TAG_EN.
module mmu_utlb #(
    parameter int unsigned ENTRIES = 4,
    parameter int unsigned IS_DATA = 0,
    parameter int unsigned ASID_W  = 8,
    parameter int unsigned TAG_W   = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [31:0]       req_vaddr,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic [ASID_W-1:0] asid,
    input  logic [2:0]        cfg_k0,
    input  logic              flush,
    output logic              resp_valid,
    output logic [TAG_W-1:0]  resp_tag,
    output logic              resp_uncache,
    output logic              resp_exc,
    output logic [4:0]        resp_exccode,
    output logic              resp_refill,
    output logic              tlb_req,
    output logic [18:0]       tlb_vpn2,
    output logic              tlb_odd,
    output logic [ASID_W-1:0] tlb_asid,
    input  logic              tlb_gnt,
    input  logic              tlb_hit,
    input  logic              tlb_v,
    input  logic              tlb_d,
    input  logic              tlb_g,
    input  logic [TAG_W-1:0]  tlb_pfn,
    input  logic [2:0]        tlb_c
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned VPN_W = 20;

    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_FILL
    } state_e;

    state_e             state_q, state_d;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic               store_q, store_d;
    logic [ASID_W-1:0]  asid_q, asid_d;
    logic               kill_q, kill_d;
    logic               treq_q, treq_d;
    logic               ready_q, ready_d;

    logic [TAG_W-1:0]   fl_pfn_q, fl_pfn_d;
    logic               fl_unc_q, fl_unc_d;
    logic               fl_d_q, fl_d_d;
    logic               fl_ok_q, fl_ok_d;
`ifdef UTLB_ASID_TAG_EN
    logic               fl_g_q, fl_g_d;
`endif

    logic               rvalid_q, rvalid_d;
    logic [TAG_W-1:0]   rtag_q, rtag_d;
    logic               runc_q, runc_d;
    logic               rexc_q, rexc_d;
    logic [4:0]         rcode_q, rcode_d;
    logic               rrefill_q, rrefill_d;

    // micro-TLB storage; only the valid bits and the replacement pointer are reset
    logic [ENTRIES-1:0] ent_valid_q;
    logic [VPN_W-1:0]   ent_vpn_q [ENTRIES];
    logic [TAG_W-1:0]   ent_pfn_q [ENTRIES];
    logic               ent_unc_q [ENTRIES];
    logic               ent_d_q   [ENTRIES];
`ifdef UTLB_ASID_TAG_EN
    logic               ent_g_q    [ENTRIES];
    logic [ASID_W-1:0]  ent_asid_q [ENTRIES];
`endif
    logic [IDX_W-1:0]   ptr_q;

    logic               fill_we;
    logic               is_store;
    logic               is_kseg0;
    logic               is_kseg1;
    logic               misalign;
    logic [ENTRIES-1:0] match;
    logic               hit;
    logic [IDX_W-1:0]   hit_idx;
    logic               unused_c;

    assign is_store = (IS_DATA != 0) && req_store;
    assign is_kseg0 = (req_vaddr[31:29] == 3'b100);
    assign is_kseg1 = (req_vaddr[31:29] == 3'b101);
    assign unused_c = ^{req_vaddr[11:2], tlb_g, req_size, req_store};

    // fetch port is always a word access
    always_comb begin
        misalign = |req_vaddr[1:0];
        if (IS_DATA != 0) begin
            case (req_size)
                2'd0:    misalign = 1'b0;
                2'd1:    misalign = req_vaddr[0];
                default: misalign = |req_vaddr[1:0];
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < int'(ENTRIES); i++) begin
            match[i] = ent_valid_q[i] && (ent_vpn_q[i] == req_vaddr[31:12]);
`ifdef UTLB_ASID_TAG_EN
            match[i] = match[i] && (ent_g_q[i] || (ent_asid_q[i] == asid));
`endif
        end
    end

    // descending scan so the lowest matching index is the one kept
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        vpn_d     = vpn_q;
        store_d   = store_q;
        asid_d    = asid_q;
        kill_d    = kill_q;
        treq_d    = treq_q;
        fl_pfn_d  = fl_pfn_q;
        fl_unc_d  = fl_unc_q;
        fl_d_d    = fl_d_q;
        fl_ok_d   = fl_ok_q;
`ifdef UTLB_ASID_TAG_EN
        fl_g_d    = fl_g_q;
`endif
        rvalid_d  = 1'b0;
        rtag_d    = rtag_q;
        runc_d    = runc_q;
        rexc_d    = rexc_q;
        rcode_d   = rcode_q;
        rrefill_d = rrefill_q;
        fill_we   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    vpn_d     = req_vaddr[31:12];
                    store_d   = is_store;
                    asid_d    = asid;
                    kill_d    = 1'b0;
                    rtag_d    = '0;
                    runc_d    = 1'b0;
                    rexc_d    = 1'b0;
                    rcode_d   = '0;
                    rrefill_d = 1'b0;
                    if (misalign) begin
                        rvalid_d = 1'b1;
                        rexc_d   = 1'b1;
                        rcode_d  = is_store ? EXC_ADES : EXC_ADEL;
                    end else if (is_kseg0 || is_kseg1) begin
                        rvalid_d = 1'b1;
                        rtag_d   = TAG_W'({3'b000, req_vaddr[28:12]});
                        runc_d   = is_kseg1 || (cfg_k0 != 3'd3);
                    end else if (hit) begin
                        rvalid_d = 1'b1;
                        if (is_store && !ent_d_q[hit_idx]) begin
                            rexc_d  = 1'b1;
                            rcode_d = EXC_MOD;
                        end else begin
                            rtag_d = ent_pfn_q[hit_idx];
                            runc_d = ent_unc_q[hit_idx];
                        end
                    end else begin
                        state_d = S_WAIT;
                        treq_d  = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (flush) begin
                    kill_d = 1'b1;
                end
                if (tlb_gnt) begin
                    state_d   = S_FILL;
                    treq_d    = 1'b0;
                    fl_pfn_d  = tlb_pfn;
                    fl_unc_d  = (tlb_c != 3'd3);
                    fl_d_d    = tlb_d;
                    fl_ok_d   = tlb_hit && tlb_v;
`ifdef UTLB_ASID_TAG_EN
                    fl_g_d    = tlb_g;
`endif
                    rvalid_d  = 1'b1;
                    rtag_d    = '0;
                    runc_d    = 1'b0;
                    rexc_d    = 1'b1;
                    rcode_d   = '0;
                    rrefill_d = 1'b0;
                    if (!tlb_hit) begin
                        rcode_d   = store_q ? EXC_TLBS : EXC_TLBL;
                        rrefill_d = 1'b1;
                    end else if (!tlb_v) begin
                        rcode_d = store_q ? EXC_TLBS : EXC_TLBL;
                    end else if (store_q && !tlb_d) begin
                        rcode_d = EXC_MOD;
                    end else begin
                        rexc_d = 1'b0;
                        rtag_d = tlb_pfn;
                        runc_d = (tlb_c != 3'd3);
                    end
                end
            end
            S_FILL: begin
                state_d = S_IDLE;
                fill_we = fl_ok_q && !kill_q && !flush;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            vpn_q     <= '0;
            store_q   <= 1'b0;
            asid_q    <= '0;
            kill_q    <= 1'b0;
            treq_q    <= 1'b0;
            ready_q   <= 1'b1;
            fl_pfn_q  <= '0;
            fl_unc_q  <= 1'b0;
            fl_d_q    <= 1'b0;
            fl_ok_q   <= 1'b0;
`ifdef UTLB_ASID_TAG_EN
            fl_g_q    <= 1'b0;
`endif
            rvalid_q  <= 1'b0;
            rtag_q    <= '0;
            runc_q    <= 1'b0;
            rexc_q    <= 1'b0;
            rcode_q   <= '0;
            rrefill_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vpn_q     <= vpn_d;
            store_q   <= store_d;
            asid_q    <= asid_d;
            kill_q    <= kill_d;
            treq_q    <= treq_d;
            ready_q   <= ready_d;
            fl_pfn_q  <= fl_pfn_d;
            fl_unc_q  <= fl_unc_d;
            fl_d_q    <= fl_d_d;
            fl_ok_q   <= fl_ok_d;
`ifdef UTLB_ASID_TAG_EN
            fl_g_q    <= fl_g_d;
`endif
            rvalid_q  <= rvalid_d;
            rtag_q    <= rtag_d;
            runc_q    <= runc_d;
            rexc_q    <= rexc_d;
            rcode_q   <= rcode_d;
            rrefill_q <= rrefill_d;
        end
    end

    // flush beats a same-cycle fill; the pointer only moves on an actual write
    always_ff @(posedge clk) begin
        if (rst) begin
            ent_valid_q <= '0;
            ptr_q       <= '0;
        end else if (flush) begin
            ent_valid_q <= '0;
        end else if (fill_we) begin
            ent_valid_q[ptr_q] <= 1'b1;
            ptr_q              <= ptr_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            ent_vpn_q[ptr_q]  <= vpn_q;
            ent_pfn_q[ptr_q]  <= fl_pfn_q;
            ent_unc_q[ptr_q]  <= fl_unc_q;
            ent_d_q[ptr_q]    <= fl_d_q;
`ifdef UTLB_ASID_TAG_EN
            ent_g_q[ptr_q]    <= fl_g_q;
            ent_asid_q[ptr_q] <= asid_q;
`endif
        end
    end

    assign req_ready    = ready_q;
    assign resp_valid   = rvalid_q;
    assign resp_tag     = rtag_q;
    assign resp_uncache = runc_q;
    assign resp_exc     = rexc_q;
    assign resp_exccode = rcode_q;
    assign resp_refill  = rrefill_q;
    assign tlb_req      = treq_q;
    assign tlb_vpn2     = vpn_q[19:1];
    assign tlb_odd      = vpn_q[0];
    assign tlb_asid     = asid_q;

endmodule

// File: tb/tb_mmu_utlb.sv
// Directed plus randomized bench for mmu_utlb (data port, 4 entries) against a queue-based micro-TLB model.
module tb_mmu_utlb;

    localparam int unsigned NE = 4;
    localparam int unsigned AW = 8;
    localparam int unsigned TW = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_vaddr;
    logic          req_store;
    logic [1:0]    req_size;
    logic [AW-1:0] asid;
    logic [2:0]    cfg_k0;
    logic          flush;
    logic          resp_valid;
    logic [TW-1:0] resp_tag;
    logic          resp_uncache;
    logic          resp_exc;
    logic [4:0]    resp_exccode;
    logic          resp_refill;
    logic          tlb_req;
    logic [18:0]   tlb_vpn2;
    logic          tlb_odd;
    logic [AW-1:0] tlb_asid;
    logic          tlb_gnt;
    logic          tlb_hit;
    logic          tlb_v;
    logic          tlb_d;
    logic          tlb_g;
    logic [TW-1:0] tlb_pfn;
    logic [2:0]    tlb_c;

    mmu_utlb #(.ENTRIES(NE), .IS_DATA(1), .ASID_W(AW), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_vaddr(req_vaddr),
        .req_store(req_store), .req_size(req_size), .asid(asid), .cfg_k0(cfg_k0),
        .flush(flush),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_uncache(resp_uncache),
        .resp_exc(resp_exc), .resp_exccode(resp_exccode), .resp_refill(resp_refill),
        .tlb_req(tlb_req), .tlb_vpn2(tlb_vpn2), .tlb_odd(tlb_odd), .tlb_asid(tlb_asid),
        .tlb_gnt(tlb_gnt), .tlb_hit(tlb_hit), .tlb_v(tlb_v), .tlb_d(tlb_d), .tlb_g(tlb_g),
        .tlb_pfn(tlb_pfn), .tlb_c(tlb_c)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic        v;
        logic        d;
        logic [19:0] pfn;
        logic [2:0]  c;
    } pte_t;

    typedef struct packed {
        logic [19:0] vpn;
        logic [19:0] pfn;
        logic        unc;
        logic        d;
    } ent_t;

    pte_t        pt [bit [19:0]];
    ent_t        utlb_q [$];
    logic [19:0] rv [6];
    int          passed = 0;
    int          fails  = 0;
    int          total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic pte_t mk_pte(input logic h, input logic v, input logic d,
                                    input logic [19:0] pfn, input logic [2:0] c);
        pte_t p;
        p.hit = h; p.v = v; p.d = d; p.pfn = pfn; p.c = c;
        return p;
    endfunction

    task automatic tlb_junk();
        tlb_hit = 1'($urandom);
        tlb_v   = 1'($urandom);
        tlb_d   = 1'($urandom);
        tlb_g   = 1'($urandom);
        tlb_pfn = 20'($urandom);
        tlb_c   = 3'($urandom);
    endtask

    task automatic model_find(input logic [19:0] vpn, output bit found, output ent_t e);
        found = 1'b0;
        e     = '0;
        foreach (utlb_q[k]) begin
            if (!found && utlb_q[k].vpn == vpn) begin
                found = 1'b1;
                e     = utlb_q[k];
            end
        end
    endtask

    // round robin over NE slots == keep only the last NE fills since the last flush
    task automatic model_fill(input ent_t e);
        utlb_q.push_back(e);
        if (utlb_q.size() > NE) void'(utlb_q.pop_front());
    endtask

    task automatic do_flush();
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        utlb_q.delete();
    endtask

    task automatic do_req(input logic [31:0] va, input logic st, input logic [1:0] sz,
                          input int n, input bit fl_wait);
        logic [19:0] vpn;
        bit          found;
        ent_t        e;
        pte_t        p;
        bit          exp_miss, exp_exc, exp_unc, exp_ref;
        logic [4:0]  exp_code;
        logic [19:0] exp_tag;
        int          exp_lat;
        bit          seen, gnt_done;
        int          cnt, lat;

        vpn      = va[31:12];
        exp_miss = 1'b0; exp_exc = 1'b0; exp_unc = 1'b0; exp_ref = 1'b0;
        exp_code = 5'h00; exp_tag = 20'h0; exp_lat = 1; p = '0;
        if ((sz == 2'd1 && va[0]) || (sz >= 2'd2 && va[1:0] != 2'b00)) begin
            exp_exc  = 1'b1;
            exp_code = st ? 5'h05 : 5'h04;
        end else if (va[31:29] == 3'b100) begin
            exp_tag = {3'b000, va[28:12]};
            exp_unc = (cfg_k0 != 3'd3);
        end else if (va[31:29] == 3'b101) begin
            exp_tag = {3'b000, va[28:12]};
            exp_unc = 1'b1;
        end else begin
            model_find(vpn, found, e);
            if (found) begin
                if (st && !e.d) begin
                    exp_exc = 1'b1; exp_code = 5'h01;
                end else begin
                    exp_tag = e.pfn; exp_unc = e.unc;
                end
            end else begin
                exp_miss = 1'b1;
                exp_lat  = 2 + n;
                if (pt.exists(vpn)) p = pt[vpn];
                if (!p.hit) begin
                    exp_exc = 1'b1; exp_code = st ? 5'h03 : 5'h02; exp_ref = 1'b1;
                end else if (!p.v) begin
                    exp_exc = 1'b1; exp_code = st ? 5'h03 : 5'h02;
                end else if (st && !p.d) begin
                    exp_exc = 1'b1; exp_code = 5'h01;
                end else begin
                    exp_tag = p.pfn; exp_unc = (p.c != 3'd3);
                end
                if (fl_wait) begin
                    utlb_q.delete();
                end else if (p.hit && p.v) begin
                    e.vpn = vpn; e.pfn = p.pfn; e.unc = (p.c != 3'd3); e.d = p.d;
                    model_fill(e);
                end
            end
        end

        @(negedge clk);
        check("resp_pulse_end", 32'(resp_valid), 32'd0);
        check("req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_vaddr = va;
        req_store = st;
        req_size  = sz;
        @(negedge clk);
        req_valid = 1'b0;
        req_vaddr = $urandom;
        req_store = 1'($urandom);
        req_size  = 2'($urandom);
        seen = 1'b0; gnt_done = 1'b0; cnt = 0; lat = 1;
        while (lat <= 40) begin
            flush = 1'b0;
            if (tlb_gnt) begin
                tlb_gnt  = 1'b0;
                gnt_done = 1'b1;
                tlb_junk();
                check("tlb_req_drop", 32'(tlb_req), 32'd0);
            end
            if (resp_valid) break;
            if (tlb_req) begin
                if (gnt_done) begin
                    check("tlb_req_once", 32'(tlb_req), 32'd0);
                end else begin
                    if (!seen) begin
                        seen = 1'b1;
                        check("tlb_vpn2", 32'(tlb_vpn2), 32'(va[31:13]));
                        check("tlb_odd", 32'(tlb_odd), 32'(va[12]));
                        check("tlb_asid", 32'(tlb_asid), 32'(asid));
                        if (fl_wait) flush = 1'b1;
                    end
                    if (cnt == n) begin
                        tlb_gnt = 1'b1;
                        tlb_hit = p.hit;
                        tlb_v   = p.v;
                        tlb_d   = p.d;
                        tlb_pfn = p.pfn;
                        tlb_c   = p.c;
                    end else begin
                        cnt++;
                    end
                end
            end
            @(negedge clk);
            lat++;
        end
        check("resp_valid", 32'(resp_valid), 32'd1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("tlb_req_seen", 32'(seen), 32'(exp_miss));
        check("resp_exc", 32'(resp_exc), 32'(exp_exc));
        check("resp_exccode", 32'(resp_exccode), 32'(exp_code));
        check("resp_refill", 32'(resp_refill), 32'(exp_ref));
        check("resp_tag", 32'(resp_tag), 32'(exp_tag));
        if (!exp_exc) check("resp_uncache", 32'(resp_uncache), 32'(exp_unc));
    endtask

    // two hits accepted on consecutive cycles, one response per cycle
    task automatic back_to_back(input logic [19:0] va_a, input logic [19:0] va_b);
        bit   fa, fb;
        ent_t ea, eb;
        model_find(va_a, fa, ea);
        model_find(va_b, fb, eb);
        @(negedge clk);
        check("b2b_ready0", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_vaddr = {va_a, 12'h000}; req_store = 1'b0; req_size = 2'd2;
        @(negedge clk);
        check("b2b_valid0", 32'(resp_valid), 32'(fa));
        check("b2b_tag0", 32'(resp_tag), 32'(ea.pfn));
        check("b2b_ready1", 32'(req_ready), 32'd1);
        req_vaddr = {va_b, 12'h000};
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_valid1", 32'(resp_valid), 32'(fb));
        check("b2b_tag1", 32'(resp_tag), 32'(eb.pfn));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [19:0] vp;
        logic [31:0] va;
        rst = 1'b1; req_valid = 1'b0; req_vaddr = '0; req_store = 1'b0; req_size = 2'd2;
        asid = 8'h05; cfg_k0 = 3'd3; flush = 1'b0; tlb_gnt = 1'b0;
        tlb_junk();
        rv = '{20'h01001, 20'h01002, 20'h01003, 20'h7FFF0, 20'hC1234, 20'hE0002};

        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_tag", 32'(resp_tag), 32'd0);
        check("rst_resp_uncache", 32'(resp_uncache), 32'd0);
        check("rst_resp_exc", 32'(resp_exc), 32'd0);
        check("rst_resp_exccode", 32'(resp_exccode), 32'd0);
        check("rst_resp_refill", 32'(resp_refill), 32'd0);
        check("rst_tlb_req", 32'(tlb_req), 32'd0);
        rst = 1'b0;

        do_req(32'hBFC00000, 1'b0, 2'd2, 0, 1'b0);
        do_req(32'h80001234, 1'b0, 2'd2, 0, 1'b0);
        cfg_k0 = 3'd2;
        do_req(32'h80001234, 1'b0, 2'd2, 0, 1'b0);
        cfg_k0 = 3'd3;

        pt[20'h00400] = mk_pte(1'b1, 1'b1, 1'b1, 20'h12345, 3'd3);
        do_req(32'h00400000, 1'b0, 2'd2, 3, 1'b0);
        do_req(32'h00400000, 1'b0, 2'd2, 0, 1'b0);
        pt[20'h00500] = mk_pte(1'b0, 1'b1, 1'b1, 20'h0AAAA, 3'd3);
        do_req(32'h00500004, 1'b0, 2'd2, 1, 1'b0);
        pt[20'h00600] = mk_pte(1'b1, 1'b0, 1'b1, 20'h0BBBB, 3'd3);
        do_req(32'h00600008, 1'b1, 2'd2, 2, 1'b0);
        pt[20'h00700] = mk_pte(1'b1, 1'b1, 1'b0, 20'h0ABCD, 3'd3);
        do_req(32'h00700010, 1'b0, 2'd2, 0, 1'b0);
        do_req(32'h00700010, 1'b1, 2'd2, 0, 1'b0);
        pt[20'h00800] = mk_pte(1'b1, 1'b1, 1'b0, 20'h55555, 3'd0);
        do_req(32'h00800000, 1'b1, 2'd2, 1, 1'b0);
        do_req(32'h00800005, 1'b0, 2'd0, 0, 1'b0);

        do_req(32'h00400001, 1'b1, 2'd1, 0, 1'b0);
        do_req(32'h00400002, 1'b0, 2'd2, 0, 1'b0);
        do_req(32'h00400003, 1'b0, 2'd0, 0, 1'b0);
        do_req(32'h00400006, 1'b0, 2'd1, 0, 1'b0);

        do_flush();
        for (int i = 0; i <= int'(NE); i++) begin
            vp = 20'h02000 + 20'(i);
            pt[vp] = mk_pte(1'b1, 1'b1, 1'b1, 20'h30000 + 20'(i), 3'd2);
            do_req({vp, 12'h000}, 1'b0, 2'd2, i % 3, 1'b0);
        end
        do_req({20'h02000, 12'h000}, 1'b0, 2'd2, 2, 1'b0);
        back_to_back(20'h02003, 20'h02004);

        pt[20'h04000] = mk_pte(1'b1, 1'b1, 1'b1, 20'h44444, 3'd3);
        do_req(32'h04000000, 1'b0, 2'd2, 2, 1'b1);
        do_req(32'h04000000, 1'b0, 2'd2, 0, 1'b0);

        pt[20'h03000] = mk_pte(1'b1, 1'b1, 1'b1, 20'h33333, 3'd3);
        @(negedge clk);
        req_valid = 1'b1; req_vaddr = 32'h03000000; req_store = 1'b0; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        check("rstmid_tlb_req_up", 32'(tlb_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        utlb_q.delete();
        check("rstmid_tlb_req", 32'(tlb_req), 32'd0);
        check("rstmid_ready", 32'(req_ready), 32'd1);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        check("rstmid_no_resp", 32'(resp_valid), 32'd0);
        do_req(32'h00400000, 1'b0, 2'd2, 1, 1'b0);

        foreach (rv[k]) begin
            pt[rv[k]] = mk_pte(1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) != 0),
                               1'($urandom), 20'($urandom), 3'($urandom));
        end
        for (int it = 0; it < 80; it++) begin
            int k;
            k  = $urandom_range(0, 9);
            if (k == 0)      va = {3'b100, 29'($urandom)};
            else if (k == 1) va = {3'b101, 29'($urandom)};
            else             va = {rv[$urandom_range(0, 5)], 12'($urandom)};
            if ($urandom_range(0, 1) == 0) va[1:0] = 2'b00;
            cfg_k0 = 3'($urandom);
            if ($urandom_range(0, 15) == 0) do_flush();
            do_req(va, 1'($urandom), 2'($urandom_range(0, 2)), $urandom_range(0, 3),
                   $urandom_range(0, 5) == 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
